mem_access_unit: RTL and testbench

Load/store sequencer between the core's execute stage and the single-port data memory (128 x 32-bit words, combinational read, write on rising CLK). It converts byte-addressed word, halfword and byte loads/stores into word-indexed memory accesses. Sub-word stores use a two-cycle read-modify-write. The unit also performs little-endian lane extraction with sign/zero extension and flags misaligned or out-of-range accesses.

---
 rtl/mem_access_unit_if.sv | 25 ++
 rtl/mem_access_unit.sv | 93 +++++++++
 tb/tb_mem_access_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request, response and data-memory signals of the load/store sequencer
interface mem_access_unit_if;
  logic        Start;
  logic        MemW;
  logic [1:0]  Size;
  logic        SignExt;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic [31:0] MemAddr;
  logic        MemWE;
  logic [31:0] MemWD;
  logic [31:0] MemRD;
  logic        Busy;
  logic        Done;
  logic        Fault;
  logic [31:0] RData;
  modport master (
    output Start, MemW, Size, SignExt, Addr, WD, MemRD,
    input  MemAddr, MemWE, MemWD, Busy, Done, Fault, RData
  );
  modport slave (
    input  Start, MemW, Size, SignExt, Addr, WD, MemRD,
    output MemAddr, MemWE, MemWD, Busy, Done, Fault, RData
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/halfword/word load-store sequencer with read-modify-write sub-word stores
module mem_access_unit #(
  parameter int ADDR_WORDS = 128
) (
  input logic CLK,
  input logic RESET_N,
  mem_access_unit_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, RMW_RD = 3'd2, STORE = 3'd3, DONE = 3'd4;
  localparam logic [31:0] ADDR_LIM = 32'(4 * ADDR_WORDS);
  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d, wd_q, wd_d, merge_q, merge_d, rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d, w_q, w_d, fault_q, fault_d;
  logic        req_fault;
  logic [4:0]  sh;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val, merge_val;
  assign req_fault = (bus.Size == 2'b11) || (bus.Size == 2'b01 && bus.Addr[0]) ||
                     (bus.Size == 2'b00 && bus.Addr[1:0] != 2'b00) || (bus.Addr >= ADDR_LIM);
  assign sh        = {addr_q[1:0], 3'b000};
  assign byte_lane = 8'(bus.MemRD >> sh);
  assign half_lane = addr_q[1] ? bus.MemRD[31:16] : bus.MemRD[15:0];
  assign load_val  = size_q == 2'b00 ? bus.MemRD :
                     size_q == 2'b01 ? {{16{sign_q & half_lane[15]}}, half_lane} :
                                       {{24{sign_q & byte_lane[7]}}, byte_lane};
  // only byte and halfword stores reach RMW_RD, so size_q[1] picks byte vs halfword
  assign merge_val = size_q[1] ? ((bus.MemRD & ~(32'hFF << sh)) | (32'(wd_q[7:0]) << sh)) :
                     addr_q[1] ? {wd_q[15:0], bus.MemRD[15:0]} : {bus.MemRD[31:16], wd_q[15:0]};
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    size_d  = size_q;
    sign_d  = sign_q;
    w_d     = w_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: if (bus.Start) begin
        addr_d  = bus.Addr;
        wd_d    = bus.WD;
        size_d  = bus.Size;
        sign_d  = bus.SignExt;
        w_d     = bus.MemW;
        fault_d = req_fault;
        state_d = req_fault ? DONE : !bus.MemW ? LOAD : bus.Size == 2'b00 ? STORE : RMW_RD;
      end
      LOAD: begin
        rdata_d = load_val;
        state_d = DONE;
      end
      RMW_RD: begin
        merge_d = merge_val;
        state_d = STORE;
      end
      STORE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wd_q    <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      w_q     <= 1'b0;
      merge_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      w_q     <= w_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end
  assign bus.MemAddr = {2'b00, addr_q[31:2]};
  assign bus.MemWE   = state_q == STORE;
  assign bus.MemWD   = state_q != STORE ? 32'h0 : (w_q && size_q == 2'b00) ? wd_q : merge_q;
  assign bus.Busy    = state_q != IDLE;
  assign bus.Done    = state_q == DONE;
  assign bus.Fault   = state_q == DONE && fault_q;
  assign bus.RData   = rdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed table, corner-case sequences and randomized checks against a byte-array model
module tb_mem_access_unit;
  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  mem_access_unit_if bus ();
  mem_access_unit #(.ADDR_WORDS(128)) dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus));
  always #5 CLK = ~CLK;
  logic [31:0] mem [128];
  assign bus.MemRD = (bus.MemAddr < 32'd128) ? mem[bus.MemAddr[6:0]] : 32'h0;
  always @(posedge CLK) if (bus.MemWE) mem[bus.MemAddr[6:0]] <= bus.MemWD;
  int compared = 0;
  int mismatched = 0;
  logic [7:0]  rb [512];
  logic [31:0] m_rdata = 32'h0;
  typedef struct {
    logic        memw;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wd;
    int          lat;
    logic        flt;
    logic [31:0] rdata;
    int          idx;
    logic [31:0] word;
  } vec_t;
  vec_t tbl [13];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] ref_word(input int i);
    return {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]};
  endfunction
  task automatic model(input logic memw, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic flt, output logic [31:0] rd);
    int n;
    logic [31:0] v;
    n = size == 2'd0 ? 4 : size == 2'd1 ? 2 : 1;
    flt = size == 2'd3 || addr >= 512 || (addr % n) != 0;
    v = 0;
    if (flt) lat = 1;
    else if (!memw) begin
      for (int j = 0; j < n; j++) v = v | (32'(rb[addr + j]) << (8 * j));
      if (sext && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
      m_rdata = v;
      lat = 2;
    end else begin
      for (int j = 0; j < n; j++) rb[addr + j] = wd[8*j +: 8];
      lat = n == 4 ? 2 : 3;
    end
    rd = m_rdata;
  endtask
  task automatic apply(input logic memw, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic flt, output int we_n, output int we_cyc);
    @(negedge CLK);
    bus.MemW = memw; bus.Size = size; bus.SignExt = sext; bus.Addr = addr; bus.WD = wd;
    bus.Start = 1'b1;
    @(posedge CLK);
    #1 bus.Start = 1'b0;
    lat = 0; flt = 1'b0; we_n = 0; we_cyc = 0;
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(negedge CLK);
      if (bus.MemWE) begin we_n++; we_cyc = n; end
      if (bus.Done) begin lat = n; flt = bus.Fault; end
    end
  endtask
  initial begin
    int lat, we_n, we_cyc, m_lat, dn;
    logic flt, m_flt;
    logic [31:0] m_rd;
    for (int i = 0; i < 128; i++) begin
      mem[i] = 32'(i);
      for (int j = 0; j < 4; j++) rb[4*i+j] = j == 0 ? 8'(i) : 8'h0;
    end
    bus.Start = 0; bus.MemW = 0; bus.Size = 0; bus.SignExt = 0; bus.Addr = 0; bus.WD = 0;
    tbl[0]  = '{1'b0, 2'd0, 1'b0, 32'h14,  32'h0,        2, 1'b0, 32'h00000005, 5, 32'h00000005};
    tbl[1]  = '{1'b1, 2'd2, 1'b0, 32'h0D,  32'h000000AB, 3, 1'b0, 32'h00000005, 3, 32'h0000AB03};
    tbl[2]  = '{1'b0, 2'd2, 1'b1, 32'h0D,  32'h0,        2, 1'b0, 32'hFFFFFFAB, 3, 32'h0000AB03};
    tbl[3]  = '{1'b0, 2'd2, 1'b0, 32'h0D,  32'h0,        2, 1'b0, 32'h000000AB, 3, 32'h0000AB03};
    tbl[4]  = '{1'b1, 2'd1, 1'b0, 32'h12,  32'h1234ABCD, 3, 1'b0, 32'h000000AB, 4, 32'hABCD0004};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 32'h10,  32'h0,        2, 1'b0, 32'hABCD0004, 4, 32'hABCD0004};
    tbl[6]  = '{1'b1, 2'd0, 1'b0, 32'h20,  32'hDEADBEEF, 2, 1'b0, 32'hABCD0004, 8, 32'hDEADBEEF};
    tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h01,  32'h0,        1, 1'b1, 32'hABCD0004, 0, 32'h00000000};
    tbl[8]  = '{1'b1, 2'd0, 1'b0, 32'h06,  32'h55555555, 1, 1'b1, 32'hABCD0004, 1, 32'h00000001};
    tbl[9]  = '{1'b0, 2'd3, 1'b1, 32'h04,  32'h0,        1, 1'b1, 32'hABCD0004, 1, 32'h00000001};
    tbl[10] = '{1'b0, 2'd0, 1'b0, 32'h200, 32'h0,        1, 1'b1, 32'hABCD0004, 0, 32'h00000000};
    tbl[11] = '{1'b0, 2'd1, 1'b1, 32'h22,  32'h0,        2, 1'b0, 32'hFFFFDEAD, 8, 32'hDEADBEEF};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h21,  32'h0,        2, 1'b0, 32'h000000BE, 8, 32'hDEADBEEF};
    repeat (2) @(negedge CLK);
    chk("reset Busy", 32'(bus.Busy), 0);
    chk("reset Done", 32'(bus.Done), 0);
    chk("reset Fault", 32'(bus.Fault), 0);
    chk("reset RData", bus.RData, 0);
    chk("reset MemAddr", bus.MemAddr, 0);
    chk("reset MemWE", 32'(bus.MemWE), 0);
    chk("reset MemWD", bus.MemWD, 0);
    RESET_N = 1'b1;
    foreach (tbl[i]) begin
      model(tbl[i].memw, tbl[i].size, tbl[i].sext, tbl[i].addr, tbl[i].wd, m_lat, m_flt, m_rd);
      apply(tbl[i].memw, tbl[i].size, tbl[i].sext, tbl[i].addr, tbl[i].wd, lat, flt, we_n, we_cyc);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("vec%0d Fault", i), 32'(flt), 32'(tbl[i].flt));
      chk($sformatf("vec%0d RData", i), bus.RData, tbl[i].rdata);
      chk($sformatf("vec%0d mem word", i), mem[tbl[i].idx], tbl[i].word);
      chk($sformatf("vec%0d MemWE count", i), 32'(we_n), 32'(tbl[i].memw && !tbl[i].flt));
      chk($sformatf("vec%0d MemWE cycle", i), 32'(we_cyc), (tbl[i].memw && !tbl[i].flt) ? 32'(tbl[i].lat - 1) : 0);
    end
    // a second request held on Start while a byte store is busy must be dropped
    @(negedge CLK);
    bus.MemW = 1; bus.Size = 2'd2; bus.SignExt = 0; bus.Addr = 32'h1A; bus.WD = 32'h55; bus.Start = 1;
    model(1'b1, 2'd2, 1'b0, 32'h1A, 32'h55, m_lat, m_flt, m_rd);
    @(posedge CLK);
    #1 bus.MemW = 1; bus.Size = 2'd0; bus.Addr = 32'h0; bus.WD = 32'hFFFFFFFF;
    dn = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge CLK);
      if (n == 1) chk("busy-start Busy", 32'(bus.Busy), 1);
      if (bus.Done) dn++;
      if (n == 3) bus.Start = 0;
    end
    chk("busy-start Done count", 32'(dn), 1);
    chk("busy-start mem[6]", mem[6], 32'h00550006);
    chk("busy-start mem[0]", mem[0], 32'h0);
    // asynchronous reset during RMW_RD abandons the store
    @(negedge CLK);
    bus.MemW = 1; bus.Size = 2'd2; bus.SignExt = 0; bus.Addr = 32'h08; bus.WD = 32'hEE; bus.Start = 1;
    @(posedge CLK);
    #1 bus.Start = 0;
    @(negedge CLK);
    chk("rst-mid Busy before", 32'(bus.Busy), 1);
    #1 RESET_N = 1'b0;
    #1;
    chk("rst-mid Busy", 32'(bus.Busy), 0);
    chk("rst-mid Done", 32'(bus.Done), 0);
    chk("rst-mid MemWE", 32'(bus.MemWE), 0);
    m_rdata = 0;
    repeat (3) @(negedge CLK);
    chk("rst-mid RData", bus.RData, 0);
    chk("rst-mid mem[2]", mem[2], ref_word(2));
    RESET_N = 1'b1;
    model(1'b0, 2'd0, 1'b0, 32'h08, 32'h0, m_lat, m_flt, m_rd);
    apply(1'b0, 2'd0, 1'b0, 32'h08, 32'h0, lat, flt, we_n, we_cyc);
    chk("rst-mid reload latency", 32'(lat), 2);
    chk("rst-mid reload RData", bus.RData, 32'h00000002);
    for (int it = 0; it < 300; it++) begin
      logic memw, sext;
      logic [1:0] size;
      logic [31:0] addr, wd;
      memw = 1'($urandom_range(0, 1));
      sext = 1'($urandom_range(0, 1));
      size = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      addr = $urandom_range(0, 15) == 0 ? $urandom : 32'($urandom_range(0, 519));
      if ($urandom_range(0, 3) != 0) addr = size == 2'd0 ? addr & ~32'h3 : size == 2'd1 ? addr & ~32'h1 : addr;
      wd = $urandom;
      model(memw, size, sext, addr, wd, m_lat, m_flt, m_rd);
      apply(memw, size, sext, addr, wd, lat, flt, we_n, we_cyc);
      chk($sformatf("rnd%0d latency", it), 32'(lat), 32'(m_lat));
      chk($sformatf("rnd%0d Fault", it), 32'(flt), 32'(m_flt));
      chk($sformatf("rnd%0d RData", it), bus.RData, m_rd);
      chk($sformatf("rnd%0d MemWE count", it), 32'(we_n), 32'(memw && !m_flt));
      if (memw && !m_flt) chk($sformatf("rnd%0d mem word", it), mem[addr[8:2]], ref_word(int'(addr[8:2])));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
